// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 key-expansion engine.
// Holds the FSM state encoding, round constants and the byte-level helpers.
// Contains no logic or storage of its own.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2,
    MIX  = 2'd3
  } state_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  // Multiplication by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k (k=0 is the most significant) of RotWord(w).
  // RotWord(a0,a1,a2,a3) = (a1,a2,a3,a0), with a0 = w[31:24].
  function automatic logic [7:0] rot_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[23:16];
      2'd1:    b = w[15:8];
      2'd2:    b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in and round-key-out streams of the key-expansion engine.
// master = key producer / round-key consumer; slave = the engine.
// Both streams use valid/ready; busy is a status output of the engine.
interface aes_key_expand_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;

  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_idx, busy
  );

  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, rk_out, rk_idx, busy
  );
endinterface

// File: rtl/aes_key_expand_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational, zero latency.
// No handshake; the caller samples po0 in the same cycle it drives pi0.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] pi0,
  output logic [7:0] po0
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv = gf_inv(pi0);
    po0 = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: accepts a key, streams round keys 0..10 on a valid/ready port.
// Latency: key accept -> rk0 next cycle; each later key 6 cycles after the previous
// handshake (3 with AES_KEY_EXPAND_SBOX4_EN). rk_out/rk_idx hold while rk_ready is low.
module aes_key_expand
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst,
  aes_key_expand_if.slave   bus
);

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   rk_idx_r;
  logic [7:0]   rcon;
  logic [31:0]  t_word;
  logic         key_ready_r;
  logic         rk_valid_r;
  logic         busy_r;

  logic [31:0]  w0n, w1n, w2n, w3n;

`ifdef AES_KEY_EXPAND_SBOX4_EN
  // All four SubWord bytes looked up in parallel.
  logic [31:0] sub_word;

  for (genvar k = 0; k < 4; k++) begin : g_sbox
    sbox u_sbox (
      .pi0 (rot_byte(key_reg[31:0], 2'(k))),
      .po0 (sub_word[31-8*k -: 8])
    );
  end
`else
  // One shared S-box walks the four bytes of RotWord(w3).
  logic [1:0] bc;
  logic [7:0] sb_in;
  logic [7:0] sb_out;

  assign sb_in = rot_byte(key_reg[31:0], bc);

  sbox u_sbox (
    .pi0 (sb_in),
    .po0 (sb_out)
  );
`endif

  // Next round key from the current one and the finished SubWord(RotWord(w3)).
  always_comb begin
    w0n = key_reg[127:96] ^ t_word ^ {rcon, 24'h000000};
    w1n = key_reg[95:64]  ^ w0n;
    w2n = key_reg[63:32]  ^ w1n;
    w3n = key_reg[31:0]   ^ w2n;
  end

  // Control FSM with registered handshake/status outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_reg     <= '0;
      rk_idx_r    <= '0;
      rcon        <= RCON_INIT;
      t_word      <= '0;
      key_ready_r <= 1'b1;
      rk_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
`ifndef AES_KEY_EXPAND_SBOX4_EN
      bc          <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            key_reg     <= bus.key_in;
            rk_idx_r    <= 4'd0;
            rcon        <= RCON_INIT;
            key_ready_r <= 1'b0;
            rk_valid_r  <= 1'b1;
            busy_r      <= 1'b1;
            state       <= EMIT;
          end
        end

        EMIT: begin
          if (bus.rk_ready) begin
            rk_valid_r <= 1'b0;
            if (rk_idx_r == NUM_ROUNDS) begin
              key_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              state       <= IDLE;
            end else begin
`ifndef AES_KEY_EXPAND_SBOX4_EN
              bc <= 2'd0;
`endif
              state <= SUB;
            end
          end
        end

        SUB: begin
`ifdef AES_KEY_EXPAND_SBOX4_EN
          t_word <= sub_word;
          state  <= MIX;
`else
          case (bc)
            2'd0:    t_word[31:24] <= sb_out;
            2'd1:    t_word[23:16] <= sb_out;
            2'd2:    t_word[15:8]  <= sb_out;
            default: t_word[7:0]   <= sb_out;
          endcase
          if (bc == 2'd3) begin
            state <= MIX;
          end else begin
            bc <= bc + 2'd1;
          end
`endif
        end

        MIX: begin
          key_reg    <= {w0n, w1n, w2n, w3n};
          rk_idx_r   <= rk_idx_r + 4'd1;
          rcon       <= xtime(rcon);
          rk_valid_r <= 1'b1;
          state      <= EMIT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.key_ready = key_ready_r;
  assign bus.rk_valid  = rk_valid_r;
  assign bus.rk_out    = key_reg;
  assign bus.rk_idx    = rk_idx_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

AES-128 key-expansion engine that accepts a 128-bit cipher key and emits the 11 round keys (rounds 0..10) one at a time over a valid/ready stream. It sits downstream of the byte-substitution `sbox` block and time-multiplexes it to compute SubWord. Its output stream feeds the AddRoundKey stage of the round datapath.

## Interface
- Parameters: none (AES-128 only; `NUM_ROUNDS` = 10 lives in the package).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `key_valid` input 1: `key_in` is valid.
- `key_ready` output 1: the engine accepts a new key.
- `key_in` input 128: cipher key; bits [127:96] are w0 and bits [31:0] are w3.
- `rk_valid` output 1: `rk_out` holds a round key.
- `rk_ready` input 1: consumer accepts `rk_out`.
- `rk_out` output 128: current round key, in the same word ordering as `key_in`.
- `rk_idx` output 4: round number of `rk_out`, 0..10.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `key_ready`=1.
  - EMIT: `rk_valid`=1.
  - SUB: SubWord, byte counter `bc` 0..3.
  - MIX: compute the next round key.
- IDLE → EMIT on `key_valid` & `key_ready`.
  - Latch `key_in` into the key register, `rk_idx`=0, `rcon`=8'h01.
  - A key offered while busy is not accepted; `key_ready`=0 outside IDLE.
- EMIT → SUB on `rk_ready` when `rk_idx`<10.
- EMIT → IDLE on `rk_ready` when `rk_idx`==10.
- SUB:
  - Drive `sbox.pi0` with byte `bc` of RotWord(w3), where RotWord(a0,a1,a2,a3)=(a1,a2,a3,a0) and a0 = w3[31:24].
  - Store `po0` into byte `bc` of temp word T.
  - Go to MIX after `bc`=3.
- MIX:
  - w0'=w0^T^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - `rk_idx`+=1.
  - `rcon`=xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Go to EMIT.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- `rk_out` and `rk_idx` are stable while `rk_valid`=1 and `rk_ready`=0. `rk_valid` never drops without a handshake.
- `rk_ready` outside EMIT is ignored.
- `rk_out` is driven directly from the key register. During SUB/MIX it shows the last emitted key and is don't-care for the consumer.

## Timing
- Reset values:
  - State IDLE.
  - `key_ready`=1, `rk_valid`=0, `busy`=0.
  - `rk_out`=0, `rk_idx`=0, `rcon`=8'h01, `bc`=0, T=0.
- Reset asserted mid-operation aborts immediately to IDLE. No further `rk_valid` is produced until a new key is accepted.
- Key handshake at cycle 0 → `rk_valid` with `rk_idx`=0 at cycle 1.
- Round-key handshake at cycle t → next `rk_valid` at cycle t+6 (SUB t+1..t+4, MIX t+5).
- With `rk_ready` tied high, `rk_idx`=10 is valid at cycle 61. `key_ready`=1 again at cycle 62.
- `sbox` is combinational: its lookup completes within the SUB cycle, with no extra latency.

## Configuration
- `AES_KEY_EXPAND_SBOX4_EN` defined:
  - Four `sbox` instances compute all of T in one SUB cycle; `bc` is removed.
  - Round-key handshake at t → next `rk_valid` at t+3.
  - With `rk_ready` tied high, `rk_idx`=10 is valid at cycle 31.
- Undefined: one `sbox` instance, four-cycle SUB (default). Outputs are bit-identical in both builds; only timing differs.

## Structure
- Package `aes_pkg`:
  - State enum (IDLE, EMIT, SUB, MIX).
  - `NUM_ROUNDS`=10 and `RCON_INIT`=8'h01.
  - `xtime` function.
  - RotWord byte-select helper.
- Sub-module: the existing `sbox` (pi0/po0), instantiated once, or four times under the macro. No other sub-module.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - rk0 equals the key.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, at cycle 61 (31 with macro).
- All-zero key:
  - rk1 = 62636363626363636263636362636363.
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random `rk_ready` backpressure on the FIPS key:
  - `rk_out`/`rk_idx` stay stable while stalled.
  - The 11 keys match the previous run in order.
  - Exactly 11 handshakes occur.
- Second `key_valid` pulsed during rounds 3..5:
  - `key_ready`=0 and the key is ignored.
  - After rk10 is accepted, `key_ready`=1; the new key then yields its own rk0 at the following cycle.
- `rst` pulsed while in SUB of round 4:
  - All outputs return to reset values asynchronously.
  - A fresh key afterwards produces the correct full schedule.
- Rcon wrap check: the internal `rcon` observed before each MIX reads 01..80,1B,36.
